dot_matrix_level_scanner: RTL and testbench

Parametrised, row-scanned bi-colour dot-matrix driver for the water-level panel. It renders the water level as a bottom-up bar graph and colours it green, amber or red by threshold. At critical level the bar blinks red. Rows are time-multiplexed one at a time, and the level is latched only at frame boundaries so a frame never tears. It sits between the level-sensing logic and the physical LED matrix pins.

---
 rtl/dot_matrix_level_scanner.sv | 83 ++++++++
 tb/tb_dot_matrix_level_scanner.sv | 99 +++++++++
 2 files changed

// File: rtl/dot_matrix_level_scanner.sv
// dot_matrix_level_scanner: row-scanned bi-colour bar-graph driver for the water-level panel
module dot_matrix_level_scanner #(
  parameter int ROWS         = 8,
  parameter int COLS         = 8,
  parameter int LEVEL_W      = 4,
  parameter int SHIFT        = 1,
  parameter int WARN_LVL     = 7,
  parameter int ALARM_LVL    = 13,
  parameter int CRIT_LVL     = 15,
  parameter int SCAN_DIV     = 1000,
  parameter int BLINK_FRAMES = 50
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               enable,
  input  logic               lamp_test,
  input  logic [LEVEL_W-1:0] water_level,
  output logic [ROWS-1:0]    row_sel,
  output logic [COLS-1:0]    red_col,
  output logic [COLS-1:0]    green_col,
  output logic               frame_start
);
  localparam int RW = $clog2(ROWS);
  localparam int DW = $clog2(SCAN_DIV);
  localparam int FW = $clog2(BLINK_FRAMES + 1);
  localparam int HW = LEVEL_W + 1;
  logic [DW-1:0]      div_cnt_q, div_cnt_d;
  logic [RW-1:0]      row_idx_q, row_idx_d;
  logic [FW-1:0]      frame_cnt_q, frame_cnt_d;
  logic [LEVEL_W-1:0] level_q, level_d;
  logic               blink_on_q, blink_on_d;
  logic [ROWS-1:0]    row_sel_q, row_sel_d;
  logic [COLS-1:0]    red_col_q, red_col_d, green_col_q, green_col_d;
  logic               frame_start_q, frame_start_d;
  logic               tick, wrap, blink_wrap, lit, red_on, green_on;
  logic [HW-1:0]      h;
  always_comb begin
    tick          = div_cnt_q == DW'(SCAN_DIV - 1);
    wrap          = tick && row_idx_q == RW'(ROWS - 1);
    blink_wrap    = wrap && frame_cnt_q == FW'(BLINK_FRAMES - 1);
    div_cnt_d     = (!enable || tick) ? '0 : div_cnt_q + DW'(1);
    row_idx_d     = (!enable || wrap) ? '0 : tick ? row_idx_q + RW'(1) : row_idx_q;
    frame_cnt_d   = (!enable || blink_wrap) ? '0 : wrap ? frame_cnt_q + FW'(1) : frame_cnt_q;
    blink_on_d    = (enable && blink_wrap) ? ~blink_on_q : blink_on_q;
    level_d       = (!enable || wrap) ? water_level : level_q;
    // Height is computed one bit wider so the +1 cannot overflow; rows beyond ROWS never exist
    h             = ({1'b0, level_q} >> SHIFT) + HW'(1);
    lit           = lamp_test || int'(row_idx_q) < int'(h);
    red_on        = lamp_test || (int'(level_q) >= CRIT_LVL ? blink_on_q : int'(level_q) >= WARN_LVL);
    green_on      = lamp_test || int'(level_q) < ALARM_LVL;
    row_sel_d     = enable ? ~(ROWS'(1) << row_idx_q) : '1;
    red_col_d     = {COLS{enable && lit && red_on}};
    green_col_d   = {COLS{enable && lit && green_on}};
    frame_start_d = enable && wrap;
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      div_cnt_q     <= '0;
      row_idx_q     <= '0;
      frame_cnt_q   <= '0;
      level_q       <= '0;
      blink_on_q    <= 1'b1;
      row_sel_q     <= '1;
      red_col_q     <= '0;
      green_col_q   <= '0;
      frame_start_q <= 1'b0;
    end else begin
      div_cnt_q     <= div_cnt_d;
      row_idx_q     <= row_idx_d;
      frame_cnt_q   <= frame_cnt_d;
      level_q       <= level_d;
      blink_on_q    <= blink_on_d;
      row_sel_q     <= row_sel_d;
      red_col_q     <= red_col_d;
      green_col_q   <= green_col_d;
      frame_start_q <= frame_start_d;
    end
  end
  assign row_sel     = row_sel_q;
  assign red_col     = red_col_q;
  assign green_col   = green_col_q;
  assign frame_start = frame_start_q;
endmodule

// File: tb/tb_dot_matrix_level_scanner.sv
// tb_dot_matrix_level_scanner: directed frame-by-frame checks of the level scanner
module tb_dot_matrix_level_scanner;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       enable = 1'b0;
  logic       lamp_test = 1'b0;
  logic [3:0] water_level = 4'd5;
  logic [7:0] row_sel, red_col, green_col;
  logic       frame_start;
  int         total = 0;
  int         passed = 0;
  dot_matrix_level_scanner #(
    .ROWS(8), .COLS(8), .LEVEL_W(4), .SHIFT(1), .WARN_LVL(7), .ALARM_LVL(13),
    .CRIT_LVL(15), .SCAN_DIV(4), .BLINK_FRAMES(2)
  ) dut (
    .clk(clk), .rst(rst), .enable(enable), .lamp_test(lamp_test),
    .water_level(water_level), .row_sel(row_sel), .red_col(red_col),
    .green_col(green_col), .frame_start(frame_start)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask
  task automatic chk_blank(input string tag);
    chk({tag, " row_sel"}, row_sel, 8'hFF);
    chk({tag, " red"}, red_col, 8'h00);
    chk({tag, " green"}, green_col, 8'h00);
    chk({tag, " frame_start"}, {7'd0, frame_start}, 8'h00);
  endtask
  // One full frame: h lit rows in colour (rd, gr); at row ev_row drive water_level/lamp_test
  task automatic frame(input string tag, input int h, input logic rd, input logic gr,
                       input int ev_row, input logic [3:0] ev_w, input logic ev_l);
    logic [7:0] one;
    logic [7:0] er, eg;
    one = 8'h01;
    for (int r = 0; r < 8; r++) begin
      if (r == ev_row) begin
        water_level = ev_w;
        lamp_test   = ev_l;
      end
      er = (lamp_test || (r < h && rd)) ? 8'hFF : 8'h00;
      eg = (lamp_test || (r < h && gr)) ? 8'hFF : 8'h00;
      for (int c = 0; c < 4; c++) begin
        @(negedge clk);
        chk($sformatf("%s r%0d c%0d row_sel", tag, r, c), row_sel, ~(one << r));
        chk($sformatf("%s r%0d c%0d red", tag, r, c), red_col, er);
        chk($sformatf("%s r%0d c%0d green", tag, r, c), green_col, eg);
        chk($sformatf("%s r%0d c%0d frame_start", tag, r, c), {7'd0, frame_start},
            {7'd0, r == 7 && c == 3});
      end
    end
  endtask
  initial begin
    #1 rst = 1'b0;
    #1 chk_blank("async_reset");
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk_blank("disabled");
    enable = 1'b1;
    frame("f1_lvl5", 3, 1'b0, 1'b1, -1, 4'd0, 1'b0);
    frame("f2_lvl5", 3, 1'b0, 1'b1, -1, 4'd0, 1'b0);
    frame("f3_lvl5_hold", 3, 1'b0, 1'b1, 0, 4'd9, 1'b0);
    frame("f4_lvl9_amber", 5, 1'b1, 1'b1, -1, 4'd0, 1'b0);
    frame("f5_lvl9_midchg", 5, 1'b1, 1'b1, 4, 4'd3, 1'b0);
    frame("f6_lvl3", 2, 1'b0, 1'b1, 0, 4'd15, 1'b0);
    frame("f7_crit_off", 8, 1'b0, 1'b0, -1, 4'd0, 1'b0);
    frame("f8_crit_off", 8, 1'b0, 1'b0, -1, 4'd0, 1'b0);
    frame("f9_crit_on", 8, 1'b1, 1'b0, -1, 4'd0, 1'b0);
    frame("f10_crit_on", 8, 1'b1, 1'b0, -1, 4'd0, 1'b0);
    frame("f11_crit_off", 8, 1'b0, 1'b0, 0, 4'd13, 1'b0);
    frame("f12_alarm", 7, 1'b1, 1'b0, -1, 4'd0, 1'b0);
    frame("f13_lamp", 7, 1'b1, 1'b0, 3, 4'd13, 1'b1);
    frame("f14_lamp", 7, 1'b1, 1'b0, -1, 4'd0, 1'b0);
    frame("f15_alarm", 7, 1'b1, 1'b0, 0, 4'd13, 1'b0);
    repeat (10) @(negedge clk);
    enable    = 1'b0;
    lamp_test = 1'b1;
    @(negedge clk);
    chk_blank("disable_wins");
    water_level = 4'd14;
    lamp_test   = 1'b0;
    repeat (3) @(negedge clk);
    chk_blank("disabled_hold");
    enable = 1'b1;
    frame("f16_reenable14", 8, 1'b1, 1'b0, -1, 4'd0, 1'b0);
    repeat (6) @(negedge clk);
    #2 rst = 1'b0;
    #1 chk_blank("midframe_reset");
    @(negedge clk);
    rst = 1'b1;
    frame("f17_after_reset", 1, 1'b0, 1'b1, -1, 4'd0, 1'b0);
    frame("f18_lvl14", 8, 1'b1, 1'b0, -1, 4'd0, 1'b0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
